// File: rtl/bcd_display_scan.sv
// Four-digit, time-multiplexed seven-segment driver for the BCD converter output.
// A LOAD strobe captures ONES/TENS/HUNDREDS/SIGN into a shadow copy; the copy moves to the
// displayed (active) registers only at a frame boundary, so one frame never mixes two results.
// Digit 0 = ones, 1 = tens, 2 = hundreds, 3 = sign. SEG and AN are active low and registered.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds and tens digits.
module bcd_display_scan #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] ONES,
    input  logic [3:0] TENS,
    input  logic [1:0] HUNDREDS,
    input  logic       SIGN,
    input  logic       LOAD,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       FRAME_DONE
);

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] PRESC_ONE = CNT_W'(1);

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD code; 10-15 are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        pat = SEG_BLANK;
        unique case (code)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Scan timing
    logic [CNT_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    logic             tick;
    logic             boundary;

    // Captured-but-not-yet-shown result
    logic [3:0] shadow_ones_q, shadow_ones_d;
    logic [3:0] shadow_tens_q, shadow_tens_d;
    logic [1:0] shadow_hund_q, shadow_hund_d;
    logic       shadow_sign_q, shadow_sign_d;
    logic       pending_q, pending_d;

    // Result currently on the display
    logic [3:0] active_ones_q, active_ones_d;
    logic [3:0] active_tens_q, active_tens_d;
    logic [1:0] active_hund_q, active_hund_d;
    logic       active_sign_q, active_sign_d;

    // Registered outputs
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic       frame_done_q, frame_done_d;

    // Prescaler and digit index: index advances once per REFRESH_DIV cycles.
    always_comb begin
        tick     = (presc_q == PRESC_MAX);
        boundary = tick && (idx_q == 2'd3);
        presc_d  = tick ? '0 : presc_q + PRESC_ONE;
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
    end

    // Double buffer: LOAD fills the shadow; the boundary tick promotes it. A LOAD on the
    // boundary tick itself goes straight to the display and leaves nothing pending.
    always_comb begin
        shadow_ones_d = shadow_ones_q;
        shadow_tens_d = shadow_tens_q;
        shadow_hund_d = shadow_hund_q;
        shadow_sign_d = shadow_sign_q;
        pending_d     = pending_q;
        active_ones_d = active_ones_q;
        active_tens_d = active_tens_q;
        active_hund_d = active_hund_q;
        active_sign_d = active_sign_q;

        if (LOAD) begin
            shadow_ones_d = ONES;
            shadow_tens_d = TENS;
            shadow_hund_d = HUNDREDS;
            shadow_sign_d = SIGN;
            if (boundary) begin
                active_ones_d = ONES;
                active_tens_d = TENS;
                active_hund_d = HUNDREDS;
                active_sign_d = SIGN;
                pending_d     = 1'b0;
            end else begin
                pending_d     = 1'b1;
            end
        end else if (boundary && pending_q) begin
            active_ones_d = shadow_ones_q;
            active_tens_d = shadow_tens_q;
            active_hund_d = shadow_hund_q;
            active_sign_d = shadow_sign_q;
            pending_d     = 1'b0;
        end
    end

    // Digit multiplexer and segment decode for the digit selected this cycle.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = ~(4'b0001 << idx_q);
        unique case (idx_q)
            2'd0: seg_d = seg_decode(active_ones_q);
            2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (active_hund_q == 2'd0 && active_tens_q == 4'd0) begin
                    seg_d = SEG_BLANK;
                end else begin
                    seg_d = seg_decode(active_tens_q);
                end
`else
                seg_d = seg_decode(active_tens_q);
`endif
            end
            2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
                if (active_hund_q == 2'd0) begin
                    seg_d = SEG_BLANK;
                end else begin
                    seg_d = seg_decode({2'b00, active_hund_q});
                end
`else
                seg_d = seg_decode({2'b00, active_hund_q});
`endif
            end
            2'd3: seg_d = active_sign_q ? SEG_MINUS : SEG_BLANK;
            default: seg_d = SEG_BLANK;
        endcase
        frame_done_d = boundary;
    end

    // Scan state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // Shadow, pending and active result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow_ones_q <= 4'd0;
            shadow_tens_q <= 4'd0;
            shadow_hund_q <= 2'd0;
            shadow_sign_q <= 1'b0;
            pending_q     <= 1'b0;
            active_ones_q <= 4'd0;
            active_tens_q <= 4'd0;
            active_hund_q <= 2'd0;
            active_sign_q <= 1'b0;
        end else begin
            shadow_ones_q <= shadow_ones_d;
            shadow_tens_q <= shadow_tens_d;
            shadow_hund_q <= shadow_hund_d;
            shadow_sign_q <= shadow_sign_d;
            pending_q     <= pending_d;
            active_ones_q <= active_ones_d;
            active_tens_q <= active_tens_d;
            active_hund_q <= active_hund_d;
            active_sign_q <= active_sign_d;
        end
    end

    // Output registers: one cycle behind index/active, all display lines off in reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            seg_q        <= SEG_BLANK;
            an_q         <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SEG        = seg_q;
    assign AN         = an_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with REFRESH_DIV = 4.
// The stimulus plans the loads of each frame window, works out which result that frame must show
// and queues the four expected digit slots; a monitor pops one entry per digit slot and compares.
module tb_bcd_display_scan;

    localparam int RD    = 4;
    localparam int FRAME = 4 * RD;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] ONES = '0;
    logic [3:0] TENS = '0;
    logic [1:0] HUNDREDS = '0;
    logic       SIGN = 1'b0;
    logic       LOAD = 1'b0;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       FRAME_DONE;

    bcd_display_scan #(
        .REFRESH_DIV(RD),
        .CNT_W      (16)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ONES      (ONES),
        .TENS      (TENS),
        .HUNDREDS  (HUNDREDS),
        .SIGN      (SIGN),
        .LOAD      (LOAD),
        .SEG       (SEG),
        .AN        (AN),
        .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] ones;
        logic [3:0] tens;
        logic [1:0] hund;
        logic       sign;
    } val_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ecount  = 0;
    bit   mon_en  = 1'b0;
    val_t shown;
    bit   plan_en  [FRAME];
    val_t plan_val [FRAME];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int code);
        return (code <= 9) ? SEG_TAB[code] : 7'h7F;
    endfunction

    // Queue the four digit slots a frame showing value v must produce.
    function automatic void push_frame(input val_t v);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.an = ~(4'b0001 << d);
            case (d)
                0: e.seg = ref_seg(int'(v.ones));
                1: e.seg = (LZB && v.hund == 0 && v.tens == 0) ? 7'h7F : ref_seg(int'(v.tens));
                2: e.seg = (LZB && v.hund == 0) ? 7'h7F : ref_seg(int'(v.hund));
                default: e.seg = v.sign ? 7'h3F : 7'h7F;
            endcase
            sb.push_back(e);
        end
    endfunction

    function automatic val_t mk(input int o, input int t, input int h, input int s);
        val_t v;
        v.ones = 4'(o);
        v.tens = 4'(t);
        v.hund = 2'(h);
        v.sign = 1'(s);
        return v;
    endfunction

    function automatic val_t rand_val();
        val_t v;
        int   n;
        if ($urandom_range(3) == 0) begin
            v.ones = 4'($urandom);
            v.tens = 4'($urandom);
            v.hund = 2'($urandom);
        end else begin
            n = $urandom_range(299);
            v.ones = 4'(n % 10);
            v.tens = 4'((n / 10) % 10);
            v.hund = 2'(n / 100);
        end
        v.sign = 1'($urandom);
        return v;
    endfunction

    task automatic clear_plan();
        for (int i = 0; i < FRAME; i++) begin
            plan_en[i]  = 1'b0;
            plan_val[i] = '0;
        end
    endtask

    task automatic rand_plan();
        for (int i = 0; i < FRAME; i++) begin
            plan_en[i]  = ($urandom_range(7) == 0);
            plan_val[i] = rand_val();
        end
    endtask

    // Drive inputs for the edge about to come; non-load cycles carry junk that must be ignored.
    task automatic drive(input bit en, input val_t v);
        val_t j;
        j        = en ? v : rand_val();
        LOAD     = en;
        ONES     = j.ones;
        TENS     = j.tens;
        HUNDREDS = j.hund;
        SIGN     = j.sign;
    endtask

    // One frame window: the last load in it is what the following frame shows.
    task automatic run_frame();
        for (int i = 0; i < FRAME; i++) begin
            if (plan_en[i]) shown = plan_val[i];
        end
        push_frame(shown);
        for (int i = 0; i < FRAME; i++) begin
            drive(plan_en[i], plan_val[i]);
            @(negedge CLK);
        end
        LOAD = 1'b0;
    endtask

    // Cycles since reset release, counted by rising edges.
    always @(posedge CLK or posedge RST) begin
        if (RST) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    // Monitor: a new digit slot starts every RD cycles; pop its expectation and hold it.
    exp_t cur;
    bit   have_cur = 1'b0;
    always @(negedge CLK) begin
        if (mon_en && !RST && ecount >= 1) begin
            if ((ecount - 1) % RD == 0) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    have_cur = 1'b0;
                    $display("FAIL sb_empty: got empty queue, expected a digit slot (t=%0t)",
                             $time);
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (have_cur) begin
                check("an", 32'(AN), 32'(cur.an));
                check("seg", 32'(SEG), 32'(cur.seg));
            end
            check("frame_done", 32'(FRAME_DONE), 32'(ecount % FRAME == 0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_an", 32'(AN), 32'hF);
        check("rst_seg", 32'(SEG), 32'h7F);
        check("rst_fd", 32'(FRAME_DONE), 32'h0);

        shown = '0;
        push_frame(shown);
        mon_en = 1'b1;
        RST    = 1'b0;

        // Frame 1: no load, still zeros.
        clear_plan();
        run_frame();
        // Frame 2: mid-window load of 125.
        clear_plan();
        plan_en[6] = 1'b1; plan_val[6] = mk(5, 2, 1, 0);
        run_frame();
        // Frame 3: -9.
        clear_plan();
        plan_en[3] = 1'b1; plan_val[3] = mk(9, 0, 0, 1);
        run_frame();
        // Frame 4: load exactly on the boundary tick.
        clear_plan();
        plan_en[FRAME-1] = 1'b1; plan_val[FRAME-1] = rand_val();
        run_frame();
        // Frame 5: 111 then 222, only 222 may appear.
        clear_plan();
        plan_en[2] = 1'b1; plan_val[2] = mk(1, 1, 1, 0);
        plan_en[9] = 1'b1; plan_val[9] = mk(2, 2, 2, 0);
        run_frame();
        for (int f = 0; f < 6; f++) begin
            rand_plan();
            run_frame();
        end

        // Reset during the digit-2 slot with a load pending.
        for (int i = 0; i < 10; i++) begin
            drive(i == 1, mk(4, 3, 2, 1));
            @(negedge CLK);
        end
        LOAD = 1'b0;
        check("an_slot2", 32'(AN), 32'hB);
        #2 RST = 1'b1;
        #1;
        check("midrst_an", 32'(AN), 32'hF);
        check("midrst_seg", 32'(SEG), 32'h7F);
        check("midrst_fd", 32'(FRAME_DONE), 32'h0);
        sb.delete();
        shown = '0;
        repeat (2) @(negedge CLK);
        push_frame(shown);
        RST = 1'b0;
        clear_plan();
        run_frame();
        for (int f = 0; f < 3; f++) begin
            rand_plan();
            run_frame();
        end

        // Let the last queued frame display, then stop.
        repeat (FRAME) @(negedge CLK);
        mon_en = 1'b0;
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
